// File: rtl/fe_diag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fe_diag_pkg: command/driver types, FSM states and DS function codes shared |
// | by the front-end diagnostic sequencer, its FIFO and the front-end model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fe_diag_pkg;

  typedef struct packed {
    logic        write;
    logic [0:6]  func;
    logic [0:35] data;
  } tFeDiagCmd;

  typedef struct packed {
    logic        driving;
    logic [0:35] data;
  } tEBUSdriver;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RELEASE = 3'd5
  } tFeDiagState;

  localparam logic [0:6] DS_WR_CRAM  = 7'o033;
  localparam logic [0:6] DS_WR_APR   = 7'o070;
  localparam logic [0:6] DS_RD_EDP   = 7'o100;
  localparam logic [0:6] DS_RD_CRAM0 = 7'o101;
  localparam logic [0:6] DS_RD_CRAM1 = 7'o102;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fe_diag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fe_diag_fifo: synchronous FIFO of diagnostic commands with full/empty/count|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fe_diag_fifo
  import fe_diag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  tFeDiagCmd                  push_cmd,
  input  logic                       pop,
  output tFeDiagCmd                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  tFeDiagCmd         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_cmd;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fe_diag_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fe_diag_seq: queued EBUS diagnostic sequencer (ds/strobe/drive/capture).   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fe_diag_seq
  import fe_diag_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdWrite,
  input  logic [0:6]  cmdFunc,
  input  logic [0:35] cmdData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [0:35] rspData,
  output logic        busy,
  output tEBUSdriver  EBUSdriver,
  input  logic [0:35] ebusData,
  output logic [0:6]  ebusDs,
  output logic        ebusDiagStrobe
);

  localparam int CW = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

  if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_timing
    $error("fe_diag_seq: SETUP/STROBE/SETTLE_CYCLES must all be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fe_diag_seq: FIFO_DEPTH must be a power of two >= 2");
  end

  tFeDiagCmd                   fifo_head;
  tFeDiagCmd                   push_cmd;
  logic                        fifo_full, fifo_empty, push, pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  tFeDiagState      state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic             write_q,     write_d;
  logic [0:6]       ds_q,        ds_d;
  logic             strobe_q,    strobe_d;
  logic             driving_q,   driving_d;
  logic [0:35]      drv_data_q,  drv_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [0:35]      rsp_data_q,  rsp_data_d;

  assign push     = cmdValid && cmdReady;
  assign push_cmd = '{write: cmdWrite, func: cmdFunc, data: cmdData};

  fe_diag_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    ds_d        = ds_q;
    strobe_d    = strobe_q;
    driving_d   = driving_q;
    drv_data_d  = drv_data_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q && !rspReady;
    pop         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          write_d    = fifo_head.write;
          ds_d       = fifo_head.func;
          driving_d  = fifo_head.write;
          drv_data_d = fifo_head.write ? fifo_head.data : '0;
          cnt_d      = SETUP_LD;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (write_q) begin
          strobe_d = 1'b1;
          cnt_d    = STROBE_LD;
          state_d  = ST_STROBE;
        end else begin
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
        end
      end
      ST_STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          strobe_d   = 1'b0;
          driving_d  = 1'b0;
          drv_data_d = '0;
          ds_d       = '0;
          state_d    = ST_RELEASE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // A capture in the same cycle as a consumer take keeps rspValid high.
        if (!rsp_valid_q || rspReady) begin
          rsp_data_d  = ebusData;
          rsp_valid_d = 1'b1;
          ds_d        = '0;
          state_d     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        ds_d       = '0;
        strobe_d   = 1'b0;
        driving_d  = 1'b0;
        drv_data_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      ds_q        <= '0;
      strobe_q    <= 1'b0;
      driving_q   <= 1'b0;
      drv_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      ds_q        <= ds_d;
      strobe_q    <= strobe_d;
      driving_q   <= driving_d;
      drv_data_q  <= drv_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmdReady           = !fifo_full;
  assign busy               = (state_q != ST_IDLE) || (fifo_count != '0);
  assign rspValid           = rsp_valid_q;
  assign rspData            = rsp_data_q;
  assign ebusDs             = ds_q;
  assign ebusDiagStrobe     = strobe_q;
  assign EBUSdriver.driving = driving_q;
  assign EBUSdriver.data    = drv_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fe_diag_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fe_diag_seq: directed self-checking bench for fe_diag_seq.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fe_diag_seq;
  import fe_diag_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cmdValid, cmdReady, cmdWrite;
  logic [0:6]  cmdFunc;
  logic [0:35] cmdData;
  logic        rspValid, rspReady;
  logic [0:35] rspData;
  logic        busy;
  tEBUSdriver  EBUSdriver;
  logic [0:35] ebusData;
  logic [0:6]  ebusDs;
  logic        ebusDiagStrobe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fe_diag_seq #(.FIFO_DEPTH(4), .SETUP_CYCLES(1), .STROBE_CYCLES(2), .SETTLE_CYCLES(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmdValid       (cmdValid),
    .cmdReady       (cmdReady),
    .cmdWrite       (cmdWrite),
    .cmdFunc        (cmdFunc),
    .cmdData        (cmdData),
    .rspValid       (rspValid),
    .rspReady       (rspReady),
    .rspData        (rspData),
    .busy           (busy),
    .EBUSdriver     (EBUSdriver),
    .ebusData       (ebusData),
    .ebusDs         (ebusDs),
    .ebusDiagStrobe (ebusDiagStrobe)
  );

  // One cycle: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmdValid = 1'b0; cmdWrite = 1'b0; cmdFunc = '0; cmdData = '0;
    rspReady = 1'b0; ebusData = '0;
    step(); step();
    reset = 1'b0;
    checks++;
    if ({cmdReady, rspValid, rspData, busy, ebusDs, ebusDiagStrobe, EBUSdriver} !==
        {1'b1, 1'b0, 36'o0, 1'b0, 7'o0, 1'b0, 1'b0, 36'o0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b rv=%b rd=%o busy=%b ds=%o stb=%b drv=%b dd=%o, exp rdy=1 rest 0",
               cmdReady, rspValid, rspData, busy, ebusDs, ebusDiagStrobe, EBUSdriver.driving, EBUSdriver.data);
    end
  endtask

  task automatic test_write();
    logic [0:35] d;
    logic [0:6]  eds;
    logic        es, edrv, eb;
    logic [0:35] edata;
    d = 36'o123456701234;
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdFunc = DS_WR_APR; cmdData = d;
    step();
    cmdValid = 1'b0;
    // c = cycles since the pop cycle
    for (int c = 0; c <= 6; c++) begin
      eds   = (c >= 1 && c <= 3) ? 7'o070 : 7'o0;
      es    = (c == 2 || c == 3);
      edrv  = (c >= 1 && c <= 3);
      edata = edrv ? d : 36'o0;
      eb    = (c < 5);
      checks++;
      if ({ebusDs, ebusDiagStrobe, EBUSdriver.driving, EBUSdriver.data, busy} !== {eds, es, edrv, edata, eb}) begin
        errors++;
        $display("FAIL write c=%0d: got ds=%o stb=%b drv=%b dd=%o busy=%b, exp ds=%o stb=%b drv=%b dd=%o busy=%b",
                 c, ebusDs, ebusDiagStrobe, EBUSdriver.driving, EBUSdriver.data, busy, eds, es, edrv, edata, eb);
      end
      step();
    end
  endtask

  task automatic test_read();
    logic [0:35] d;
    logic [0:6]  eds;
    logic        ev, eb;
    logic [0:35] erd;
    d = 36'o777000111222;
    ebusData = d; rspReady = 1'b1;
    cmdValid = 1'b1; cmdWrite = 1'b0; cmdFunc = DS_RD_EDP; cmdData = 36'o555555555555;
    step();
    cmdValid = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      eds = (c >= 1 && c <= 5) ? 7'o100 : 7'o0;
      ev  = (c == 6);
      erd = (c >= 6) ? d : 36'o0;
      eb  = (c < 7);
      checks++;
      if ({ebusDs, ebusDiagStrobe, EBUSdriver.driving, EBUSdriver.data, rspValid, rspData, busy} !==
          {eds, 1'b0, 1'b0, 36'o0, ev, erd, eb}) begin
        errors++;
        $display("FAIL read c=%0d: got ds=%o stb=%b drv=%b dd=%o rv=%b rd=%o busy=%b, exp ds=%o stb=0 drv=0 dd=0 rv=%b rd=%o busy=%b",
                 c, ebusDs, ebusDiagStrobe, EBUSdriver.driving, EBUSdriver.data, rspValid, rspData, busy, eds, ev, erd, eb);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [0:6] funcs [5];
    logic [0:6] eds;
    logic       erdy, eb, rdy;
    int         idx, k, m;
    funcs = '{7'o011, 7'o022, 7'o033, 7'o044, 7'o055};
    idx = 0;
    for (int c = 0; c <= 27; c++) begin
      if (idx < 5) begin
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdFunc = funcs[idx]; cmdData = 36'(idx + 1);
      end else begin
        cmdValid = 1'b0;
      end
      // cmd k pops in cycle 1+5k, so its ds is visible in cycles 2+5k .. 4+5k
      eds = 7'o0;
      if (c >= 2) begin
        k = (c - 2) / 5;
        m = (c - 2) % 5;
        if (k < 5 && m < 3) eds = funcs[k];
      end
      erdy = !(c == 5 || c == 6);
      eb   = (c >= 1 && c <= 25);
      checks++;
      if ({ebusDs, cmdReady, busy} !== {eds, erdy, eb}) begin
        errors++;
        $display("FAIL b2b c=%0d: got ds=%o rdy=%b busy=%b, exp ds=%o rdy=%b busy=%b",
                 c, ebusDs, cmdReady, busy, eds, erdy, eb);
      end
      rdy = cmdReady;
      step();
      if (rdy && cmdValid) idx++;
    end
    cmdValid = 1'b0;
    checks++;
    if (idx !== 5) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d, exp 5", idx);
    end
  endtask

  task automatic test_stall_reads();
    logic [0:35] prev, d1, d2a, d2b, erd;
    logic [0:6]  eds;
    logic        ev, eb;
    prev = 36'o777000111222;
    d1   = 36'o111111111111;
    d2a  = 36'o222222222222;
    d2b  = 36'o333333333333;
    for (int c = 0; c <= 21; c++) begin
      case (c)
        0:  begin cmdValid = 1'b1; cmdWrite = 1'b0; cmdFunc = DS_RD_CRAM0; ebusData = d1; rspReady = 1'b0; end
        1:  cmdFunc = DS_RD_CRAM1;
        2:  cmdValid = 1'b0;
        10: ebusData = d2a;
        17: begin ebusData = d2b; rspReady = 1'b1; end
        18: rspReady = 1'b0;
        19: rspReady = 1'b1;
        20: rspReady = 1'b0;
        default: ;
      endcase
      eds = (c >= 2 && c <= 6) ? 7'o101 : (c >= 9 && c <= 17) ? 7'o102 : 7'o0;
      ev  = (c >= 7 && c <= 19);
      erd = (c < 7) ? prev : (c < 18) ? d1 : d2b;
      eb  = (c >= 1 && c <= 18);
      checks++;
      if ({ebusDs, ebusDiagStrobe, EBUSdriver.driving, rspValid, rspData, busy} !== {eds, 1'b0, 1'b0, ev, erd, eb}) begin
        errors++;
        $display("FAIL stall c=%0d: got ds=%o stb=%b drv=%b rv=%b rd=%o busy=%b, exp ds=%o stb=0 drv=0 rv=%b rd=%o busy=%b",
                 c, ebusDs, ebusDiagStrobe, EBUSdriver.driving, rspValid, rspData, busy, eds, ev, erd, eb);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [0:35] d;
    d = 36'o765432107654;
    cmdValid = 1'b1; cmdWrite = 1'b1; cmdFunc = DS_WR_CRAM; cmdData = d;
    step();
    cmdWrite = 1'b0; cmdFunc = DS_RD_CRAM0;
    step();
    cmdFunc = DS_RD_CRAM1;
    step();
    cmdValid = 1'b0;
    checks++;
    if ({ebusDs, ebusDiagStrobe, EBUSdriver.driving, EBUSdriver.data} !== {7'o033, 1'b1, 1'b1, d}) begin
      errors++;
      $display("FAIL mid_strobe: got ds=%o stb=%b drv=%b dd=%o, exp ds=33 stb=1 drv=1 dd=%o",
               ebusDs, ebusDiagStrobe, EBUSdriver.driving, EBUSdriver.data, d);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({ebusDs, ebusDiagStrobe, EBUSdriver, busy, cmdReady, rspValid, rspData} !==
          {7'o0, 1'b0, 1'b0, 36'o0, 1'b0, 1'b1, 1'b0, 36'o0}) begin
        errors++;
        $display("FAIL post_reset c=%0d: got ds=%o stb=%b drv=%b dd=%o busy=%b rdy=%b rv=%b rd=%o, exp rdy=1 rest 0",
                 c, ebusDs, ebusDiagStrobe, EBUSdriver.driving, EBUSdriver.data, busy, cmdReady, rspValid, rspData);
      end
      step();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_stall_reads();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
